// File: rtl/sram_bridge_pkg.sv
// Shared constants and sizing helpers for the multi-bank SRAM bridge.
package sram_bridge_pkg;

    localparam int RD_LAT_MIN    = 1;
    localparam int RD_LAT_MAX    = 4;
    localparam int NUM_BANKS_MIN = 1;
    localparam int NUM_BANKS_MAX = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Zero when a single bank leaves no bank field in the address.
    function automatic int bank_w(input int num_banks);
        return clog2(num_banks);
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency tracker: carries an issued read's bank index for DEPTH clocks.
// done pulses in the clock the selected bank presents valid data.
module sram_rd_pipe #(
    parameter int DEPTH = 1,
    parameter int IW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [IW-1:0] push_bank,
    output logic          done,
    output logic [IW-1:0] done_bank
);

    logic [DEPTH-1:0] vld;
    logic [IW-1:0]    idx [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                idx[s] <= '0;
            end
        end else begin
            vld[0] <= push;
            idx[0] <= push_bank;
            for (int s = 1; s < DEPTH; s++) begin
                vld[s] <= vld[s-1];
                idx[s] <= idx[s-1];
            end
        end
    end

    assign done      = vld[DEPTH-1];
    assign done_bank = idx[DEPTH-1];

endmodule

// File: rtl/sram_bridge_multi.sv
// Wishbone pipelined slave bridging to NUM_BANKS single-port synchronous SRAMs.
// Reads and writes share one SRAM address bus; a same-cycle read displaces a pending write.
module sram_bridge_multi
    import sram_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_BANKS = 2,
    parameter int BANK_AW   = 6,
    parameter int RD_LAT    = 1,
    parameter int ADDR_W    = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        wb_cyc_i,
    input  logic                        wb_stb_i,
    input  logic                        wb_we_i,
    input  logic [ADDR_W-1:0]           wb_adr_i,
    input  logic [DATA_W/8-1:0]         wb_sel_i,
    input  logic [DATA_W-1:0]           wb_dat_i,
    output logic [DATA_W-1:0]           wb_dat_o,
    output logic                        wb_ack_o,
    output logic                        wb_err_o,
    output logic                        wb_rty_o,
    output logic                        wb_stall_o,
    output logic [BANK_AW-1:0]          sram_addr_o,
    output logic [DATA_W-1:0]           sram_data_o,
    output logic [DATA_W/8-1:0]         sram_be_o,
    output logic [NUM_BANKS-1:0]        sram_re_o,
    output logic [NUM_BANKS-1:0]        sram_we_o,
    input  logic [NUM_BANKS*DATA_W-1:0] sram_data_i
);

    localparam int SW       = lanes(DATA_W);
    localparam int LSB      = clog2(SW);
    localparam int BW       = bank_w(NUM_BANKS);
    localparam int BIW      = (BW > 0) ? BW : 1;
    localparam int BANK_LSB = LSB + BANK_AW;

    logic               en;
    logic               rd_req;
    logic               wr_req;
    logic               rd_go;
    logic               wr_issue;
    logic               mapped;
    logic [BANK_AW-1:0] wofs;
    logic [BIW-1:0]     bank;

    logic               rip;
    logic               wip;
    logic               d0_vld;
    logic [BANK_AW-1:0] d0_addr;
    logic [DATA_W-1:0]  d0_dat;
    logic [SW-1:0]      d0_sel;
    logic [BIW-1:0]     d0_bank;

    logic               ack_rd;
    logic               err_rd;
    logic               err_wr;
    logic [DATA_W-1:0]  dat_q;

    logic               done;
    logic [BIW-1:0]     done_bank;
    logic               unused_adr;

    // Bus is ignored while reset is held so no strobe can leak out.
    assign en     = wb_cyc_i & wb_stb_i & rst_n_i;
    assign rd_req = en & ~wb_we_i & ~rip;
    assign wr_req = en & wb_we_i & ~wip;

    assign wofs = wb_adr_i[LSB +: BANK_AW];

    always_comb begin
        bank = '0;
        if (BW > 0) begin
            bank = BIW'(wb_adr_i >> BANK_LSB);
        end
    end

    assign mapped     = (int'(bank) < NUM_BANKS);
    assign unused_adr = ^wb_adr_i;

    assign rd_go    = rd_req & mapped;
    assign wr_issue = d0_vld & ~rd_go;

    always_comb begin
        sram_re_o   = '0;
        sram_we_o   = '0;
        sram_addr_o = '0;
        sram_data_o = '0;
        sram_be_o   = '0;
        if (rd_go) begin
            sram_re_o   = NUM_BANKS'(1) << bank;
            sram_addr_o = wofs;
        end else if (wr_issue) begin
            sram_we_o   = NUM_BANKS'(1) << d0_bank;
            sram_addr_o = d0_addr;
            sram_data_o = d0_dat;
            sram_be_o   = d0_sel;
        end
    end

    sram_rd_pipe #(
        .DEPTH (RD_LAT),
        .IW    (BIW)
    ) u_rd_pipe (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (rd_go),
        .push_bank (bank),
        .done      (done),
        .done_bank (done_bank)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rip     <= 1'b0;
            wip     <= 1'b0;
            d0_vld  <= 1'b0;
            d0_addr <= '0;
            d0_dat  <= '0;
            d0_sel  <= '0;
            d0_bank <= '0;
            ack_rd  <= 1'b0;
            err_rd  <= 1'b0;
            err_wr  <= 1'b0;
            dat_q   <= '0;
        end else begin
            ack_rd <= done;
            err_rd <= rd_req & ~mapped;
            err_wr <= wr_req & ~mapped;

            if (done) begin
                dat_q <= sram_data_i[int'(done_bank)*DATA_W +: DATA_W];
            end

            if (rd_req) begin
                rip <= 1'b1;
            end else if (ack_rd || err_rd) begin
                rip <= 1'b0;
            end

            if (wr_req) begin
                wip <= 1'b1;
            end else if (wr_issue || err_wr) begin
                wip <= 1'b0;
            end

            // A write waits in d0 until a cycle with no read request.
            if (wr_req && mapped) begin
                d0_vld  <= 1'b1;
                d0_addr <= wofs;
                d0_dat  <= wb_dat_i;
                d0_sel  <= wb_sel_i;
                d0_bank <= bank;
            end else if (wr_issue) begin
                d0_vld <= 1'b0;
            end
        end
    end

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_rd | wr_issue;
    assign wb_err_o   = err_rd | err_wr;
    assign wb_rty_o   = 1'b0;
    assign wb_stall_o = en & ~(wb_ack_o | wb_err_o);

endmodule

// File: tb/tb_sram_bridge_multi.sv
// Self-checking bench for sram_bridge_multi with a behavioural SRAM and shadow memory.
// Three banks of 64 words, read latency 3; bank field value 3 is unmapped.
module tb_sram_bridge_multi;

    localparam int NB    = 3;
    localparam int AW    = 6;
    localparam int LAT   = 3;
    localparam int WORDS = 64;

    logic              clk;
    logic              rst_n;
    logic              cyc;
    logic              stb;
    logic              we;
    logic [15:0]       adr;
    logic [3:0]        sel;
    logic [31:0]       wdat;
    logic [31:0]       rdat;
    logic              ack;
    logic              err;
    logic              rty;
    logic              stall;
    logic [AW-1:0]     s_addr;
    logic [31:0]       s_wdata;
    logic [3:0]        s_be;
    logic [NB-1:0]     s_re;
    logic [NB-1:0]     s_we;
    logic [NB*32-1:0]  s_rdata;

    int checks;
    int failures;

    sram_bridge_multi #(
        .DATA_W    (32),
        .NUM_BANKS (NB),
        .BANK_AW   (AW),
        .RD_LAT    (LAT),
        .ADDR_W    (16)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .wb_cyc_i    (cyc),
        .wb_stb_i    (stb),
        .wb_we_i     (we),
        .wb_adr_i    (adr),
        .wb_sel_i    (sel),
        .wb_dat_i    (wdat),
        .wb_dat_o    (rdat),
        .wb_ack_o    (ack),
        .wb_err_o    (err),
        .wb_rty_o    (rty),
        .wb_stall_o  (stall),
        .sram_addr_o (s_addr),
        .sram_data_o (s_wdata),
        .sram_be_o   (s_be),
        .sram_re_o   (s_re),
        .sram_we_o   (s_we),
        .sram_data_i (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    // Behavioural SRAM banks: data valid LAT clocks after re, junk otherwise.
    bit [31:0] smem  [NB][WORDS];
    bit [31:0] spipe [NB][LAT];
    bit        svld  [NB][LAT];
    bit [31:0] junk;

    always @(posedge clk) begin
        junk <= $urandom;
        for (int k = 0; k < NB; k++) begin
            if (s_we[k]) smem[k][s_addr] <= merge(smem[k][s_addr], s_wdata, s_be);
            svld[k][0]  <= s_re[k];
            spipe[k][0] <= smem[k][s_addr];
            for (int s = 1; s < LAT; s++) begin
                svld[k][s]  <= svld[k][s-1];
                spipe[k][s] <= spipe[k][s-1];
            end
        end
    end

    always_comb begin
        s_rdata = '0;
        for (int k = 0; k < NB; k++) begin
            s_rdata[k*32 +: 32] = svld[k][LAT-1] ? spipe[k][LAT-1] : (junk ^ 32'(k + 1));
        end
    end

    // Shadow memory: what each mapped word must hold after completed writes.
    bit [31:0] ref_mem [NB][WORDS];

    function automatic logic [15:0] mk_adr(input int b, input int w);
        return 16'((b << 8) | (w << 2));
    endfunction

    int          o_lat;
    logic        o_err;
    logic        o_ack;
    logic        o_stall_bad;
    logic        o_done_stall;
    logic        o_excl_bad;
    int          o_re_n;
    int          o_we_n;
    logic [2:0]  o_re;
    logic [2:0]  o_we;
    logic [5:0]  o_re_addr;
    logic [5:0]  o_we_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_be;
    logic [31:0] o_dat;

    // Drives one bus transaction, holding stb until ack/err, and records observations.
    task automatic bus_xfer(input logic wr, input logic [15:0] a, input logic [3:0] s,
                            input logic [31:0] d);
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = s; wdat = d;
        o_lat = -1; o_err = 0; o_ack = 0; o_stall_bad = 0; o_done_stall = 0;
        o_excl_bad = 0; o_re_n = 0; o_we_n = 0; o_re = 0; o_we = 0;
        o_re_addr = 0; o_we_addr = 0; o_wdata = 0; o_be = 0; o_dat = 0;
        for (int n = 0; n < 24; n++) begin
            @(negedge clk);
            if (s_re != 0) begin
                o_re_n++; o_re |= s_re; o_re_addr = s_addr;
            end
            if (s_we != 0) begin
                o_we_n++; o_we |= s_we; o_we_addr = s_addr;
                o_wdata = s_wdata; o_be = s_be;
            end
            if ((s_re & s_we) != 0) o_excl_bad = 1;
            if (ack || err) begin
                o_lat = n; o_ack = ack; o_err = err; o_dat = rdat; o_done_stall = stall;
                break;
            end
            if (stall !== 1'b1) o_stall_bad = 1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic test_reset;
        int acks;
        repeat (2) @(negedge clk);
        checks++;
        if ({ack, err, stall, rty, s_re, s_we, s_addr, s_wdata, s_be, rdat} !== '0) begin
            failures++;
            $display("FAIL reset_hold outs ack=%b err=%b stall=%b re=%b we=%b addr=%h dat=%h want 0",
                     ack, err, stall, s_re, s_we, s_addr, rdat);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({ack, err, stall, rty, s_re, s_we, s_addr, s_wdata, s_be, rdat} !== '0) begin
            failures++;
            $display("FAIL reset_release outs ack=%b err=%b stall=%b re=%b we=%b want 0",
                     ack, err, stall, s_re, s_we);
        end
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = mk_adr(1, 2); sel = 4'hF;
        @(negedge clk);
        checks++;
        if (s_re !== 3'b010) begin
            failures++;
            $display("FAIL reset_pre_re got=%b want=010", s_re);
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack, err, stall, s_re, s_we, s_addr, s_be, rdat} !== '0) begin
            failures++;
            $display("FAIL reset_mid outs ack=%b re=%b we=%b dat=%h want 0", ack, s_re, s_we, rdat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int n = 0; n < LAT + 4; n++) begin
            @(negedge clk);
            if (ack || err || s_re != 0 || s_we != 0) acks++;
        end
        checks++;
        if (acks !== 0) begin
            failures++;
            $display("FAIL reset_discard activity_cycles got=%0d want=0", acks);
        end
        @(posedge clk); #1;
        bus_xfer(1'b1, mk_adr(2, 2), 4'hF, 32'h1234_5678);
        ref_mem[2][2] = merge(ref_mem[2][2], 32'h1234_5678, 4'hF);
        checks++;
        if (o_lat !== 1 || o_we !== 3'b100 || o_we_addr !== 6'd2) begin
            failures++;
            $display("FAIL reset_first_wr lat=%0d we=%b addr=%0d want 1/100/2", o_lat, o_we, o_we_addr);
        end
        bus_xfer(1'b0, mk_adr(2, 2), 4'hF, 32'h0);
        checks++;
        if (o_lat !== LAT + 1 || o_dat !== ref_mem[2][2]) begin
            failures++;
            $display("FAIL reset_first_rd lat=%0d dat=%h want %0d/%h", o_lat, o_dat, LAT + 1, ref_mem[2][2]);
        end
    endtask

    task automatic test_write_read;
        bus_xfer(1'b1, 16'h0104, 4'hF, 32'hDEAD_BEEF);
        ref_mem[1][1] = merge(ref_mem[1][1], 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (o_we !== 3'b010 || o_we_addr !== 6'd1 || o_be !== 4'hF || o_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL wr_strobe we=%b addr=%0d be=%h d=%h want 010/1/f/deadbeef",
                     o_we, o_we_addr, o_be, o_wdata);
        end
        checks++;
        if (o_lat !== 1 || o_ack !== 1'b1 || o_re_n !== 0 || o_we_n !== 1) begin
            failures++;
            $display("FAIL wr_timing lat=%0d ack=%b re_n=%0d we_n=%0d want 1/1/0/1",
                     o_lat, o_ack, o_re_n, o_we_n);
        end
        bus_xfer(1'b0, 16'h0104, 4'hF, 32'h0);
        checks++;
        if (o_re !== 3'b010 || o_re_addr !== 6'd1 || o_re_n !== 1 || o_we_n !== 0) begin
            failures++;
            $display("FAIL rd_strobe re=%b addr=%0d re_n=%0d we_n=%0d want 010/1/1/0",
                     o_re, o_re_addr, o_re_n, o_we_n);
        end
        checks++;
        if (o_lat !== LAT + 1 || o_dat !== ref_mem[1][1] || o_stall_bad || o_done_stall) begin
            failures++;
            $display("FAIL rd_data lat=%0d dat=%h stall_bad=%b want %0d/%h/0",
                     o_lat, o_dat, o_stall_bad | o_done_stall, LAT + 1, ref_mem[1][1]);
        end
    endtask

    task automatic test_byte_enable;
        bus_xfer(1'b1, mk_adr(0, 5), 4'hF, 32'h1122_3344);
        ref_mem[0][5] = merge(ref_mem[0][5], 32'h1122_3344, 4'hF);
        bus_xfer(1'b1, mk_adr(0, 5), 4'b0010, 32'h0000_AB00);
        ref_mem[0][5] = merge(ref_mem[0][5], 32'h0000_AB00, 4'b0010);
        checks++;
        if (o_be !== 4'b0010 || o_wdata !== 32'h0000_AB00 || o_we !== 3'b001 || o_lat !== 1) begin
            failures++;
            $display("FAIL byte_en be=%b d=%h we=%b lat=%0d want 0010/0000ab00/001/1",
                     o_be, o_wdata, o_we, o_lat);
        end
        bus_xfer(1'b0, mk_adr(0, 5), 4'h0, 32'h0);
        checks++;
        if (o_dat !== ref_mem[0][5]) begin
            failures++;
            $display("FAIL byte_en_rd got=%h want=%h", o_dat, ref_mem[0][5]);
        end
    endtask

    task automatic test_unmapped;
        int busy;
        for (int i = 0; i < 2; i++) begin
            bus_xfer(i[0], 16'h0300 | 16'(i * 28), 4'hF, 32'hCAFE_F00D);
            checks++;
            if (o_lat !== 1 || o_err !== 1'b1 || o_ack !== 1'b0 || o_re_n !== 0 || o_we_n !== 0) begin
                failures++;
                $display("FAIL unmapped_%0d lat=%0d err=%b ack=%b re_n=%0d we_n=%0d want 1/1/0/0/0",
                         i, o_lat, o_err, o_ack, o_re_n, o_we_n);
            end
            busy = 0;
            for (int n = 0; n < LAT + 2; n++) begin
                @(negedge clk);
                if (ack || err || s_re != 0 || s_we != 0) busy++;
            end
            @(posedge clk); #1;
            checks++;
            if (busy !== 0) begin
                failures++;
                $display("FAIL unmapped_quiet_%0d busy_cycles got=%0d want=0", i, busy);
            end
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        int          got_n;
        int          acks;
        logic [31:0] got_dat;
        d = $urandom;
        cyc = 1; stb = 1; we = 1; adr = mk_adr(0, 9); sel = 4'b1001; wdat = d;
        @(negedge clk);
        checks++;
        if (s_we !== 3'b000 || s_re !== 3'b000 || ack !== 1'b0) begin
            failures++;
            $display("FAIL coll_req we=%b re=%b ack=%b want 0/0/0", s_we, s_re, ack);
        end
        @(posedge clk); #1;
        we = 0; adr = mk_adr(2, 7); sel = 4'h0;
        @(negedge clk);
        checks++;
        if (s_re !== 3'b100 || s_addr !== 6'd7 || s_we !== 3'b000 || ack !== 1'b0) begin
            failures++;
            $display("FAIL coll_read_first re=%b addr=%0d we=%b ack=%b want 100/7/000/0",
                     s_re, s_addr, s_we, ack);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_we !== 3'b001 || s_addr !== 6'd9 || s_wdata !== d || s_be !== 4'b1001 ||
            ack !== 1'b1 || s_re !== 3'b000) begin
            failures++;
            $display("FAIL coll_write_late we=%b addr=%0d d=%h be=%b ack=%b want 001/9/%h/1001/1",
                     s_we, s_addr, s_wdata, s_be, ack, d);
        end
        ref_mem[0][9] = merge(ref_mem[0][9], d, 4'b1001);
        got_n = -1; acks = 0; got_dat = 0;
        for (int n = 2; n < 12; n++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (s_re != 0 || s_we != 0) acks += 100;
            if (ack) begin
                acks++;
                if (got_n < 0) begin
                    got_n = n; got_dat = rdat;
                    @(posedge clk); #1;
                    cyc = 0; stb = 0;
                end
            end
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        checks++;
        if (got_n !== LAT + 1 || acks !== 1 || got_dat !== ref_mem[2][7]) begin
            failures++;
            $display("FAIL coll_read_ack at=%0d acks=%0d dat=%h want %0d/1/%h",
                     got_n, acks, got_dat, LAT + 1, ref_mem[2][7]);
        end
        bus_xfer(1'b0, mk_adr(0, 9), 4'h0, 32'h0);
        checks++;
        if (o_dat !== ref_mem[0][9]) begin
            failures++;
            $display("FAIL coll_readback got=%h want=%h", o_dat, ref_mem[0][9]);
        end
    endtask

    task automatic test_abandon;
        int          got_n;
        int          acks;
        logic [31:0] got_dat;
        logic [31:0] d;
        cyc = 1; stb = 1; we = 0; adr = mk_adr(1, 12); sel = 4'hF;
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        got_n = -1; acks = 0; got_dat = 0;
        for (int n = 1; n < LAT + 5; n++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                if (got_n < 0) begin
                    got_n = n; got_dat = rdat;
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (got_n !== LAT + 1 || acks !== 1 || got_dat !== ref_mem[1][12]) begin
            failures++;
            $display("FAIL abandon_rd at=%0d acks=%0d dat=%h want %0d/1/%h",
                     got_n, acks, got_dat, LAT + 1, ref_mem[1][12]);
        end
        d = $urandom;
        cyc = 1; stb = 1; we = 1; adr = mk_adr(0, 60); sel = 4'hF; wdat = d;
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        checks++;
        if (s_we !== 3'b001 || s_addr !== 6'd60 || ack !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL abandon_wr we=%b addr=%0d ack=%b stall=%b want 001/60/1/0",
                     s_we, s_addr, ack, stall);
        end
        ref_mem[0][60] = merge(ref_mem[0][60], d, 4'hF);
        @(posedge clk); #1;
        bus_xfer(1'b0, mk_adr(0, 60), 4'h0, 32'h0);
        checks++;
        if (o_dat !== ref_mem[0][60] || o_lat !== LAT + 1) begin
            failures++;
            $display("FAIL abandon_readback dat=%h lat=%0d want %h/%0d",
                     o_dat, o_lat, ref_mem[0][60], LAT + 1);
        end
    endtask

    task automatic test_back_to_back;
        int b;
        int w;
        for (int i = 0; i < 8; i++) begin
            b = i % NB;
            w = $urandom_range(0, WORDS - 1);
            bus_xfer(1'b0, mk_adr(b, w), 4'h0, 32'h0);
            checks++;
            if (o_lat !== LAT + 1 || o_re_n !== 1 || o_re !== 3'(1 << b) ||
                o_dat !== ref_mem[b][w] || o_stall_bad || o_done_stall) begin
                failures++;
                $display("FAIL b2b_%0d lat=%0d re_n=%0d re=%b dat=%h want %0d/1/%b/%h",
                         i, o_lat, o_re_n, o_re, o_dat, LAT + 1, 3'(1 << b), ref_mem[b][w]);
            end
        end
    endtask

    task automatic test_random;
        int          b;
        int          w;
        logic        wr;
        logic [15:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        for (int i = 0; i < 80; i++) begin
            b  = $urandom_range(0, 3);
            w  = $urandom_range(0, WORDS - 1);
            wr = 1'($urandom_range(0, 1));
            s  = 4'($urandom_range(0, 15));
            d  = $urandom;
            a  = 16'(($urandom_range(0, 63) << 10) | (b << 8) | (w << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
            bus_xfer(wr, a, s, d);
            checks++;
            if (o_stall_bad || o_done_stall || o_excl_bad) begin
                failures++;
                $display("FAIL rnd_%0d_stall stall_bad=%b excl=%b want 0", i,
                         o_stall_bad | o_done_stall, o_excl_bad);
            end
            if (b >= NB) begin
                checks++;
                if (o_lat !== 1 || o_err !== 1'b1 || o_ack !== 1'b0 || o_re_n !== 0 || o_we_n !== 0) begin
                    failures++;
                    $display("FAIL rnd_%0d_unmapped lat=%0d err=%b ack=%b re_n=%0d we_n=%0d",
                             i, o_lat, o_err, o_ack, o_re_n, o_we_n);
                end
            end else if (wr) begin
                checks++;
                if (o_lat !== 1 || o_ack !== 1'b1 || o_we_n !== 1 || o_re_n !== 0 ||
                    o_we !== 3'(1 << b) || o_we_addr !== 6'(w) || o_be !== s || o_wdata !== d) begin
                    failures++;
                    $display("FAIL rnd_%0d_wr lat=%0d we=%b addr=%0d be=%b d=%h want 1/%b/%0d/%b/%h",
                             i, o_lat, o_we, o_we_addr, o_be, o_wdata, 3'(1 << b), w, s, d);
                end
                ref_mem[b][w] = merge(ref_mem[b][w], d, s);
            end else begin
                checks++;
                if (o_lat !== LAT + 1 || o_ack !== 1'b1 || o_re_n !== 1 || o_we_n !== 0 ||
                    o_re !== 3'(1 << b) || o_re_addr !== 6'(w) || o_dat !== ref_mem[b][w]) begin
                    failures++;
                    $display("FAIL rnd_%0d_rd lat=%0d re=%b addr=%0d dat=%h want %0d/%b/%0d/%h",
                             i, o_lat, o_re, o_re_addr, o_dat, LAT + 1, 3'(1 << b), w, ref_mem[b][w]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; adr = '0; sel = '0; wdat = '0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_unmapped();
        test_collision();
        test_abandon();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
